// File: rtl/bias_stream_reader.sv
// Bias ROM reader: walks a wrapping address window and streams
// sign-extended bias values to the MAC stage over valid/ready.
module bias_stream_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int NUM_CH = 32,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ACC_W-1:0]  m_data,
  output logic [ADDR_W-1:0] m_index,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] AMASK = ADDR_W'(NUM_CH - 1);
  localparam logic [CW-1:0] NCH = CW'(NUM_CH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   issued;
  logic [CW-1:0]   req;
  logic [CW-1:0]   req_clamp;
  logic            load;
  logic            hs_last;

  assign req       = {1'b0, count};
  assign req_clamp = (req > NCH) ? NCH : req;

  // A new element may be loaded whenever the output slot is free
  // or is being emptied at this same edge.
  assign load    = (state == RUN) && (issued < cnt)
                 && (!m_valid || m_ready);
  assign hs_last = m_valid && m_ready && m_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      issued   <= '0;
      rom_addr <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_index  <= '0;
      m_last   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            rom_addr <= base_addr & AMASK;
            cnt      <= req_clamp;
            issued   <= '0;
            if (count != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (load) begin
            m_data   <= ACC_W'($signed(rom_data));
            m_index  <= issued[ADDR_W-1:0];
            m_last   <= (issued == cnt - 1'b1);
            m_valid  <= 1'b1;
            issued   <= issued + 1'b1;
            rom_addr <= (rom_addr + 1'b1) & AMASK;
          end else if (m_ready) begin
            m_valid <= 1'b0;
          end
          if (hs_last) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bias_stream_reader.sv
// Randomized self-checking bench for bias_stream_reader against a
// queue-free arithmetic model of the bias window.
module tb_bias_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  base_addr;
  logic [5:0]  count;
  logic [5:0]  rom_addr;
  logic [7:0]  rom_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic [5:0]  m_index;
  logic        m_last;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rom_data = 8'h7C + {3'b000, rom_addr[4:0]};

  bias_stream_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_index   (m_index),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [15:0] exp_bias(input int b, input int i);
    int a;
    int v;
    a = (b + i) % 32;
    v = (124 + a) % 256;
    if (v >= 128) v = v - 256;
    return 16'(v);
  endfunction

  // mode 0: ready high, 1: random ready, 2: fixed 1,0,0,1,1 pattern
  task automatic run_burst(input int b, input int c, input int mode,
                           input bit inj, input string nm);
    int n;
    int got;
    int cyc;
    int first_v;
    int last_hs;
    int exp_cyc;
    bit fin;
    bit stall;
    bit rdy;
    logic [15:0] pd;
    logic [5:0]  pi;
    logic [5:0]  pa;
    logic        pl;
    logic [15:0] ed;
    int pat[5] = '{1, 0, 0, 1, 1};
    n = (c > 32) ? 32 : c;
    got = 0; cyc = 0; first_v = -1; last_hs = -1;
    fin = 0; stall = 0;
    pd = '0; pi = '0; pa = '0; pl = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = 6'(b); count = 6'(c); m_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; base_addr = 6'($urandom); count = 6'($urandom);
    checks++;
    if (busy !== (n != 0))
      $display("FAIL %s busy_after_start got %b want %b", nm, busy, n != 0);
    if (busy !== (n != 0)) errors++;
    if (n != 0) begin
      checks++;
      if (rom_addr !== 6'(b % 32)) begin
        errors++;
        $display("FAIL %s rom_addr_base got %0d want %0d", nm, rom_addr, b % 32);
      end
    end
    while (!fin && cyc < 400) begin
      if (done === 1'b1) begin
        fin = 1;
        checks++;
        if (got != n) begin
          errors++;
          $display("FAIL %s beat_count got %0d want %0d", nm, got, n);
        end
        exp_cyc = (n == 0) ? 0 : last_hs + 1;
        checks++;
        if (cyc != exp_cyc) begin
          errors++;
          $display("FAIL %s done_time got %0d want %0d", nm, cyc, exp_cyc);
        end
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s idle_at_done got busy=%b valid=%b want 0 0", nm, busy, m_valid);
        end
        if (inj) begin
          start = 1'b1; base_addr = 6'd0; count = 6'd5;
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s after_done got done=%b busy=%b valid=%b want 0 0 0",
                   nm, done, busy, m_valid);
        end
      end else begin
        if (stall) begin
          checks++;
          if (m_valid !== 1'b1 || m_data !== pd || m_index !== pi ||
              m_last !== pl || rom_addr !== pa) begin
            errors++;
            $display("FAIL %s stall_hold got %b %h %0d %b %0d want 1 %h %0d %b %0d",
                     nm, m_valid, m_data, m_index, m_last, rom_addr, pd, pi, pl, pa);
          end
        end
        if (m_valid === 1'b1 && first_v < 0) begin
          first_v = cyc;
          checks++;
          if (cyc != 1) begin
            errors++;
            $display("FAIL %s first_valid got %0d want 1", nm, cyc);
          end
        end
        case (mode)
          1: rdy = 1'($urandom);
          2: rdy = (cyc < 5) ? 1'(pat[cyc]) : 1'b1;
          default: rdy = 1'b1;
        endcase
        m_ready = rdy;
        if (m_valid === 1'b1) begin
          checks++;
          if (got >= n) begin
            errors++;
            $display("FAIL %s extra_beat got %0d want <%0d", nm, got, n);
          end else begin
            ed = exp_bias(b, got);
            if (m_data !== ed || m_index !== 6'(got) ||
                m_last !== (got == n - 1) ||
                rom_addr !== 6'((b + got + 1) % 32)) begin
              errors++;
              $display("FAIL %s beat%0d got %h %0d %b a%0d want %h %0d %b a%0d",
                       nm, got, m_data, m_index, m_last, rom_addr,
                       ed, got, got == n - 1, (b + got + 1) % 32);
            end
          end
          if (rdy) begin
            last_hs = cyc;
            got++;
          end
        end
        stall = (m_valid === 1'b1) && !rdy;
        pd = m_data; pi = m_index; pl = m_last; pa = rom_addr;
        if (inj && cyc == 5) begin
          start = 1'b1; base_addr = 6'd9; count = 6'd3;
        end
        @(negedge clk);
        start = 1'b0;
        cyc++;
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL %s timeout got %0d beats want done", nm, got);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; m_ready = 1'b1;
    base_addr = 6'd7; count = 6'd4;
    #12;
    checks++;
    if ({rom_addr, m_valid, m_data, m_index, m_last, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_state got a%0d v%b d%h i%0d l%b b%b dn%b want all 0",
               rom_addr, m_valid, m_data, m_index, m_last, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b0;
  endtask

  task automatic test_basic;
    run_burst(0, 4, 0, 0, "basic");
  endtask

  task automatic test_wrap;
    run_burst(30, 3, 0, 0, "wrap");
  endtask

  task automatic test_backpressure;
    run_burst(4, 3, 2, 0, "backpressure");
  endtask

  task automatic test_zero_and_ignored;
    run_burst(5, 0, 0, 1, "zero_count");
    run_burst(0, 32, 0, 1, "ignored_start");
  endtask

  task automatic test_random;
    for (int k = 0; k < 12; k++)
      run_burst(int'($urandom_range(63, 0)), int'($urandom_range(40, 0)),
                1, 1'($urandom), "random");
  endtask

  task automatic test_back_to_back;
    run_burst(31, 33, 0, 0, "clamp_b2b");
    run_burst(17, 1, 1, 0, "single_b2b");
  endtask

  task automatic test_async_reset;
    int got;
    int cyc;
    got = 0; cyc = 0;
    @(negedge clk);
    start = 1'b1; base_addr = 6'd3; count = 6'd8; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (got < 2 && cyc < 50) begin
      if (m_valid === 1'b1) got++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (got < 2) begin
      errors++;
      $display("FAIL async_reset_setup got %0d beats want 2", got);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rom_addr, m_valid, m_data, m_index, m_last, busy, done} !== '0) begin
      errors++;
      $display("FAIL async_reset got a%0d v%b d%h i%0d l%b b%b dn%b want all 0",
               rom_addr, m_valid, m_data, m_index, m_last, busy, done);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got done=%b valid=%b want 0 0", done, m_valid);
    end
    rst_n = 1'b1;
    m_ready = 1'b0;
    run_burst(1, 1, 0, 0, "reset_recover");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_backpressure;
    test_zero_and_ignored;
    test_back_to_back;
    test_random;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
